// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: start/opcode/operands in, busy/done/result out.
// SEQ_ALU_FLAGS_EN adds Carry_o and Overflow_o to both modports.
interface seq_alu_if #(parameter int DATA_WIDTH = 32);
   logic                  start_i;
   logic [3:0]            ALU_Operation_i;
   logic [DATA_WIDTH-1:0] A_i;
   logic [DATA_WIDTH-1:0] B_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  Zero_o;
   logic [DATA_WIDTH-1:0] ALU_Result_o;
`ifdef SEQ_ALU_FLAGS_EN
   logic                  Carry_o;
   logic                  Overflow_o;

   modport master (output start_i, ALU_Operation_i, A_i, B_i,
                   input  busy_o, done_o, Zero_o, ALU_Result_o, Carry_o, Overflow_o);
   modport slave  (input  start_i, ALU_Operation_i, A_i, B_i,
                   output busy_o, done_o, Zero_o, ALU_Result_o, Carry_o, Overflow_o);
`else
   modport master (output start_i, ALU_Operation_i, A_i, B_i,
                   input  busy_o, done_o, Zero_o, ALU_Result_o);
   modport slave  (input  start_i, ALU_Operation_i, A_i, B_i,
                   output busy_o, done_o, Zero_o, ALU_Result_o);
`endif
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops plus iterative shift-add multiply and restoring divide.
// Optional SEQ_ALU_FLAGS_EN adds ADD/SUB carry and signed-overflow outputs.
//
// state | meaning
// IDLE  | accepts start_i; single-cycle ops complete here
// MUL   | one shift-add step per cycle, W steps
// DIV   | one restoring-divide quotient bit per cycle, W steps
module seq_alu #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic      clk,
   input  logic      reset,
   seq_alu_if.slave  bus
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [3:0] OP_ADD   = 4'b0000, OP_SUB  = 4'b0001, OP_OR    = 4'b0010,
                          OP_SLL   = 4'b0011, OP_SRL  = 4'b0100, OP_LUI   = 4'b0101,
                          OP_AND   = 4'b0110, OP_XOR  = 4'b0111, OP_SRA   = 4'b1000,
                          OP_SLT   = 4'b1001, OP_SLTU = 4'b1010, OP_MUL   = 4'b1011,
                          OP_MULHU = 4'b1100, OP_DIVU = 4'b1101, OP_REMU  = 4'b1110;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state, state_nxt;
   logic [3:0]         op_q;
   logic [W-1:0]       opd_a, opd_b;
   logic [2*W-1:0]     acc;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_tc;
   logic               load_res, done_q, zero_q;
   logic [W-1:0]       res_q, res_nxt, sc_res;
   logic [W:0]         add_full, sub_full, mul_sum, div_shift, div_trial;
   logic [2*W-1:0]     mul_acc_nxt;
   logic [W-1:0]       rem_nxt, quo_nxt;
   logic [SHAMT_W-1:0] shamt;

   assign shamt    = bus.B_i[SHAMT_W-1:0];
   assign add_full = {1'b0, bus.A_i} + {1'b0, bus.B_i};
   assign sub_full = {1'b0, bus.A_i} + {1'b0, ~bus.B_i} + (W+1)'(1);
   assign cnt_tc   = (cnt == CNT_W'(1));

   always_comb begin
      sc_res = '0;
      case (bus.ALU_Operation_i)
         OP_ADD:  sc_res = add_full[W-1:0];
         OP_SUB:  sc_res = sub_full[W-1:0];
         OP_OR:   sc_res = bus.A_i | bus.B_i;
         OP_SLL:  sc_res = bus.A_i << shamt;
         OP_SRL:  sc_res = bus.A_i >> shamt;
         OP_LUI:  sc_res = bus.B_i;
         OP_AND:  sc_res = bus.A_i & bus.B_i;
         OP_XOR:  sc_res = bus.A_i ^ bus.B_i;
         OP_SRA:  sc_res = $signed(bus.A_i) >>> shamt;
         OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(bus.A_i) < $signed(bus.B_i))};
         OP_SLTU: sc_res = {{(W-1){1'b0}}, (bus.A_i < bus.B_i)};
         default: sc_res = '0;
      endcase
   end

   // MUL: opd_a = multiplicand, opd_b = multiplier shifted right each step.
   assign mul_sum     = {1'b0, acc[2*W-1:W]} + {1'b0, (opd_b[0] ? opd_a : '0)};
   assign mul_acc_nxt = {mul_sum, acc[W-1:1]};

   // DIV: acc[W-1:0] = partial remainder, opd_a = dividend/quotient shift, opd_b = divisor.
   // A zero divisor never fails the trial subtract, giving all-ones quotient and rem = A.
   assign div_shift = {acc[W-1:0], opd_a[W-1]};
   assign div_trial = div_shift - {1'b0, opd_b};
   assign rem_nxt   = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
   assign quo_nxt   = {opd_a[W-2:0], ~div_trial[W]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_res  = 1'b0;
      res_nxt   = sc_res;
      case (state)
         IDLE: begin
            if (bus.start_i) begin
               case (bus.ALU_Operation_i)
                  OP_MUL, OP_MULHU: state_nxt = MUL;
                  OP_DIVU, OP_REMU: state_nxt = DIV;
                  default:          load_res  = 1'b1;
               endcase
            end
         end
         MUL: begin
            res_nxt = (op_q == OP_MULHU) ? mul_acc_nxt[2*W-1:W] : mul_acc_nxt[W-1:0];
            if (cnt_tc) begin
               state_nxt = IDLE;
               load_res  = 1'b1;
            end
         end
         DIV: begin
            res_nxt = (op_q == OP_REMU) ? rem_nxt : quo_nxt;
            if (cnt_tc) begin
               state_nxt = IDLE;
               load_res  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= '0;
         opd_a  <= '0;
         opd_b  <= '0;
         acc    <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         zero_q <= 1'b0;
         res_q  <= '0;
      end else begin
         done_q <= load_res;
         if (load_res) begin
            res_q  <= res_nxt;
            zero_q <= (res_nxt == '0);
         end
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  op_q  <= bus.ALU_Operation_i;
                  opd_a <= bus.A_i;
                  opd_b <= bus.B_i;
                  acc   <= '0;
                  cnt   <= CNT_W'(W);
               end
            end
            MUL: begin
               acc   <= mul_acc_nxt;
               opd_b <= opd_b >> 1;
               cnt   <= cnt - CNT_W'(1);
            end
            DIV: begin
               acc[W-1:0] <= rem_nxt;
               opd_a      <= quo_nxt;
               cnt        <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o       = (state != IDLE);
   assign bus.done_o       = done_q;
   assign bus.Zero_o       = zero_q;
   assign bus.ALU_Result_o = res_q;

`ifdef SEQ_ALU_FLAGS_EN
   logic carry_q, ovf_q, carry_nxt, ovf_nxt;

   always_comb begin
      carry_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      if (state == IDLE) begin
         if (bus.ALU_Operation_i == OP_ADD) begin
            carry_nxt = add_full[W];
            ovf_nxt   = (bus.A_i[W-1] == bus.B_i[W-1]) && (add_full[W-1] != bus.A_i[W-1]);
         end else if (bus.ALU_Operation_i == OP_SUB) begin
            carry_nxt = sub_full[W];
            ovf_nxt   = (bus.A_i[W-1] != bus.B_i[W-1]) && (sub_full[W-1] != bus.A_i[W-1]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load_res) begin
         carry_q <= carry_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   assign bus.Carry_o    = carry_q;
   assign bus.Overflow_o = ovf_q;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: vector table for single-cycle ops,
// hand-written sequences for multiply/divide, busy-ignore and async reset.
module tb_seq_alu;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_alu_if #(.DATA_WIDTH(W)) bus ();
   seq_alu #(.DATA_WIDTH(W), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [W-1:0] last_res;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [W-1:0] a, b, res;
      logic       z, c, v;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mc(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp);
      int cyc = 0, busy_cnt = 0, unstable = 0;
      @(negedge clk);
      bus.start_i = 1'b1; bus.ALU_Operation_i = op; bus.A_i = a; bus.B_i = b;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.A_i = ~a; bus.B_i = ~b;
      cyc = 1;
      while (bus.done_o !== 1'b1 && cyc < 100) begin
         if (bus.busy_o === 1'b1) busy_cnt++;
         if (bus.ALU_Result_o !== last_res) unstable++;
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, W'(cyc), 33);
      check({name, " busy cycles"}, W'(busy_cnt), 32);
      check({name, " held result"}, W'(unstable), 0);
      check({name, " busy at done"}, W'(bus.busy_o), 0);
      check({name, " result"}, bus.ALU_Result_o, exp);
      check({name, " zero"}, W'(bus.Zero_o), W'(exp == '0));
`ifdef SEQ_ALU_FLAGS_EN
      check({name, " carry"}, W'(bus.Carry_o), 0);
      check({name, " overflow"}, W'(bus.Overflow_o), 0);
`endif
      last_res = exp;
      @(posedge clk); #1;
      check({name, " done pulse width"}, W'(bus.done_o), 0);
   endtask

   initial begin
      int pulses;
      logic [W-1:0] seen;

      vecs[0]  = '{"add ovf",   4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{"sub zero",  4'b0001, 32'h5,         32'h5,         32'h0,         1'b1, 1'b1, 1'b0};
      vecs[2]  = '{"or",        4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"sll 31",    4'b0011, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"sll wrap",  4'b0011, 32'h3,         32'd36,        32'h30,        1'b0, 1'b0, 1'b0};
      vecs[5]  = '{"srl",       4'b0100, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"lui",       4'b0101, 32'h1234,      32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"and",       4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"xor",       4'b0111, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"sra 33",    4'b1000, 32'h8000_0000, 32'd33,        32'hC000_0000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"slt",       4'b1001, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0};
      vecs[11] = '{"sltu",      4'b1010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b0};
      vecs[12] = '{"sub borrow",4'b0001, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{"reserved",  4'b1111, 32'h5,         32'h6,         32'h0,         1'b1, 1'b0, 1'b0};
      vecs[14] = '{"add wrap",  4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b1, 1'b0};

      reset = 1'b0;
      bus.start_i = 1'b0; bus.ALU_Operation_i = 4'h0; bus.A_i = '0; bus.B_i = '0;
      last_res = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", W'(bus.busy_o), 0);
      check("reset done", W'(bus.done_o), 0);
      check("reset zero", W'(bus.Zero_o), 0);
      check("reset result", bus.ALU_Result_o, 0);
`ifdef SEQ_ALU_FLAGS_EN
      check("reset carry", W'(bus.Carry_o), 0);
      check("reset overflow", W'(bus.Overflow_o), 0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // Back-to-back single-cycle ops: start_i stays high across the whole table.
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         bus.start_i = 1'b1;
         bus.ALU_Operation_i = vecs[i].op;
         bus.A_i = vecs[i].a;
         bus.B_i = vecs[i].b;
         @(posedge clk); #1;
         check({vecs[i].name, " done"}, W'(bus.done_o), 1);
         check({vecs[i].name, " busy"}, W'(bus.busy_o), 0);
         check({vecs[i].name, " result"}, bus.ALU_Result_o, vecs[i].res);
         check({vecs[i].name, " zero"}, W'(bus.Zero_o), W'(vecs[i].z));
`ifdef SEQ_ALU_FLAGS_EN
         check({vecs[i].name, " carry"}, W'(bus.Carry_o), W'(vecs[i].c));
         check({vecs[i].name, " overflow"}, W'(bus.Overflow_o), W'(vecs[i].v));
`endif
         last_res = vecs[i].res;
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      check("idle done", W'(bus.done_o), 0);
      check("idle hold", bus.ALU_Result_o, last_res);

      mc("mul",        4'b1011, 32'hFFFF_FFFF, 32'h2,       32'hFFFF_FFFE);
      mc("mulhu",      4'b1100, 32'hFFFF_FFFF, 32'h2,       32'h0000_0001);
      mc("mul lo zero",4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0);
      mc("mulhu big",  4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      mc("divu",       4'b1101, 32'd100,       32'd7,       32'd14);
      mc("remu",       4'b1110, 32'd100,       32'd7,       32'd2);
      mc("divu by 0",  4'b1101, 32'd5,         32'd0,       32'hFFFF_FFFF);
      mc("remu by 0",  4'b1110, 32'd5,         32'd0,       32'd5);

      // ADD requested while a divide is busy must be dropped.
      @(negedge clk);
      bus.start_i = 1'b1; bus.ALU_Operation_i = 4'b1101; bus.A_i = 32'd100; bus.B_i = 32'd7;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("ignore busy before add", W'(bus.busy_o), 1);
      bus.start_i = 1'b1; bus.ALU_Operation_i = 4'b0000; bus.A_i = 32'd1; bus.B_i = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      pulses = 0;
      seen = '0;
      for (int i = 0; i < 45; i++) begin
         if (bus.done_o === 1'b1) begin
            pulses++;
            seen = bus.ALU_Result_o;
         end
         @(posedge clk); #1;
      end
      check("ignore done count", W'(pulses), 1);
      check("ignore result", seen, 32'd14);
      last_res = 32'd14;

      // Async reset in the middle of a multiply.
      @(negedge clk);
      bus.start_i = 1'b1; bus.ALU_Operation_i = 4'b1011; bus.A_i = 32'd3; bus.B_i = 32'd5;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid mul busy", W'(bus.busy_o), 1);
      check("mid mul held", bus.ALU_Result_o, last_res);
      reset = 1'b0;
      #1;
      check("async rst busy", W'(bus.busy_o), 0);
      check("async rst done", W'(bus.done_o), 0);
      check("async rst zero", W'(bus.Zero_o), 0);
      check("async rst result", bus.ALU_Result_o, 0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) pulses++;
      end
      check("post rst quiet", W'(pulses), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
